shared_port_mux: RTL

//  Downstream of the two-pipeline round-robin arbiter: consumes grant_1/grant_2 and

---
 rtl/shared_port_mux.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/shared_port_mux.sv
// rtl/shared_port_mux.sv - shared bus port behind the two-pipeline arbiter
//
// Captures the granted pipeline's command into a command FIFO and issues the
// commands in order to one shared bus port over a valid/ready handshake. Each
// issued command leaves its source id in a tag FIFO. The in-order bus responses
// pop that tag and are steered back to the pipeline that issued the command.
//
// Optional feature: define RSP_TIMEOUT_EN to add the response watchdog. When it
// fires, the oldest outstanding command is answered with all-ones data.
//
// Ports
//   clk, reset_n                 clock and asynchronous active-low reset
//   grant_1/2                    registered arbiter grants
//   addr_x, wdata_x, we_x        command fields per pipeline
//   cmd_full                     registered back-pressure to the pipelines
//   bus_valid/ready, bus_addr,
//   bus_wdata, bus_we            command handshake to the shared bus
//   bus_rsp_valid/rdata          in-order responses from the shared bus
//   rsp_valid_x, rsp_rdata_x     response strobe and data per pipeline
//   err                          sticky protocol error
module shared_port_mux #(
   parameter int AW             = 8,
   parameter int DW             = 32,
   parameter int DEPTH          = 4,
   parameter int OUTSTANDING    = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          grant_1,
   input  logic          grant_2,
   input  logic [AW-1:0] addr_1,
   input  logic [AW-1:0] addr_2,
   input  logic [DW-1:0] wdata_1,
   input  logic [DW-1:0] wdata_2,
   input  logic          we_1,
   input  logic          we_2,
   output logic          cmd_full,
   output logic          bus_valid,
   input  logic          bus_ready,
   output logic [AW-1:0] bus_addr,
   output logic [DW-1:0] bus_wdata,
   output logic          bus_we,
   input  logic          bus_rsp_valid,
   input  logic [DW-1:0] bus_rsp_rdata,
   output logic          rsp_valid_1,
   output logic          rsp_valid_2,
   output logic [DW-1:0] rsp_rdata_1,
   output logic [DW-1:0] rsp_rdata_2,
   output logic          err
);

   localparam int CPW = $clog2(DEPTH);
   localparam int CCW = CPW + 1;
   localparam int TPW = $clog2(OUTSTANDING);
   localparam int TCW = TPW + 1;

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("DEPTH must be a power of two >= 2");
   end
   if ((OUTSTANDING < 2) || ((OUTSTANDING & (OUTSTANDING - 1)) != 0)) begin : g_bad_outstanding
      $error("OUTSTANDING must be a power of two >= 2");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be >= 1");
   end

   // Command FIFO. The source bit is 0 for pipeline 1 and 1 for pipeline 2.
   logic [AW-1:0]  c_addr  [DEPTH];
   logic [DW-1:0]  c_wdata [DEPTH];
   logic           c_we    [DEPTH];
   logic           c_src   [DEPTH];
   logic [CPW-1:0] c_wr, c_rd;
   logic [CCW-1:0] c_cnt, c_cnt_next;

   // Tag FIFO: one source bit per issued-but-unanswered command
   logic           t_src [OUTSTANDING];
   logic [TPW-1:0] t_wr, t_rd;
   logic [TCW-1:0] t_cnt;

   logic push_req, push_ok, both_grants, pop, t_pop, timeout_fire, err_set;
   logic [DW-1:0] rsp_data;

`ifdef RSP_TIMEOUT_EN
   localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TOW-1:0] to_cnt;
   // Fires on the edge where the counter would reach TIMEOUT_CYCLES; a real response wins.
   assign timeout_fire = (t_cnt != '0) && !bus_rsp_valid && (to_cnt == TOW'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_fire = 1'b0;
`endif

   always_comb begin
      both_grants = grant_1 & grant_2;
      push_req    = grant_1 ^ grant_2;
      bus_valid   = (c_cnt != '0) && (t_cnt < TCW'(OUTSTANDING));
      pop         = bus_valid && bus_ready;
      // A full FIFO still accepts when the head leaves in the same cycle.
      push_ok     = push_req && ((c_cnt < CCW'(DEPTH)) || pop);
      c_cnt_next  = c_cnt + CCW'(push_ok) - CCW'(pop);
      bus_addr    = c_addr[c_rd];
      bus_wdata   = c_wdata[c_rd];
      bus_we      = c_we[c_rd];
      t_pop       = (bus_rsp_valid && (t_cnt != '0)) || timeout_fire;
      rsp_data    = timeout_fire ? {DW{1'b1}} : bus_rsp_rdata;
      err_set     = both_grants || (push_req && !push_ok) ||
                    (bus_rsp_valid && (t_cnt == '0)) || timeout_fire;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            c_addr[i]  <= '0;
            c_wdata[i] <= '0;
            c_we[i]    <= 1'b0;
            c_src[i]   <= 1'b0;
         end
         for (int i = 0; i < OUTSTANDING; i++) begin
            t_src[i] <= 1'b0;
         end
         c_wr        <= '0;
         c_rd        <= '0;
         c_cnt       <= '0;
         t_wr        <= '0;
         t_rd        <= '0;
         t_cnt       <= '0;
         cmd_full    <= 1'b0;
         rsp_valid_1 <= 1'b0;
         rsp_valid_2 <= 1'b0;
         rsp_rdata_1 <= '0;
         rsp_rdata_2 <= '0;
         err         <= 1'b0;
      end else begin
         if (push_ok) begin
            c_addr[c_wr]  <= grant_2 ? addr_2 : addr_1;
            c_wdata[c_wr] <= grant_2 ? wdata_2 : wdata_1;
            c_we[c_wr]    <= grant_2 ? we_2 : we_1;
            c_src[c_wr]   <= grant_2;
            c_wr          <= c_wr + 1'b1;
         end
         if (pop) begin
            c_rd         <= c_rd + 1'b1;
            t_src[t_wr]  <= c_src[c_rd];
            t_wr         <= t_wr + 1'b1;
         end
         if (t_pop) begin
            t_rd <= t_rd + 1'b1;
         end
         c_cnt       <= c_cnt_next;
         t_cnt       <= t_cnt + TCW'(pop) - TCW'(t_pop);
         // Asserted one entry early because grants arrive a cycle after the request.
         cmd_full    <= (c_cnt_next >= CCW'(DEPTH - 1));
         rsp_valid_1 <= t_pop && !t_src[t_rd];
         rsp_valid_2 <= t_pop && t_src[t_rd];
         if (t_pop && !t_src[t_rd]) rsp_rdata_1 <= rsp_data;
         if (t_pop && t_src[t_rd])  rsp_rdata_2 <= rsp_data;
         err         <= err | err_set;
      end
   end

`ifdef RSP_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         to_cnt <= '0;
      end else if ((t_cnt == '0) || bus_rsp_valid || timeout_fire) begin
         to_cnt <= '0;
      end else begin
         to_cnt <= to_cnt + 1'b1;
      end
   end
`endif

endmodule
